// File: rtl/spi_shifter_pkg.sv
// Shared opcodes, FSM state encoding and status bit positions for the SPI shift/rotate unit.
package spi_shifter_pkg;

  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_SAR = 4'b1000;
  localparam logic [3:0] OP_ROL = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1010;

  localparam int unsigned ST_INV   = 3;
  localparam int unsigned ST_ZERO  = 2;
  localparam int unsigned ST_SIGN  = 1;
  localparam int unsigned ST_CARRY = 0;

  typedef enum logic [2:0] {
    IDLE,
    RX_OP,
    RX_A,
    RX_B,
    EXEC,
    TX,
    WAIT_NSS
  } state_t;

endpackage

// File: rtl/spi_if.sv
// Four-wire SPI bus as seen from either end.
interface spi_if;
  logic sclk;
  logic mosi;
  logic nss;
  logic miso;

  modport SLAVE  (input sclk, mosi, nss, output miso);
  modport MASTER (output sclk, mosi, nss, input miso);
endinterface

// File: rtl/spi_shift_alu.sv
// Combinational shift/rotate core producing the result and {invalid, zero, sign, carry}.
module spi_shift_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]               i_opcode,
  input  logic [WIDTH-1:0]         i_a,
  input  logic [$clog2(WIDTH)-1:0] i_amount,
  output logic [WIDTH-1:0]         o_result,
  output logic [3:0]               o_status
);
  import spi_shifter_pkg::*;

  // One guard bit beyond the operand catches the last bit shifted out as carry.
  logic [WIDTH:0]     w_lsh;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_ash;
  logic [2*WIDTH-1:0] w_rol;
  logic [2*WIDTH-1:0] w_ror;
  logic               w_carry;
  logic               w_inv;

  assign w_lsh = {1'b0, i_a} << i_amount;
  assign w_rsh = {i_a, 1'b0} >> i_amount;
  assign w_ash = $signed({i_a, 1'b0}) >>> i_amount;
  assign w_rol = {i_a, i_a} << i_amount;
  assign w_ror = {i_a, i_a} >> i_amount;

  always_comb begin
    o_result = i_a;
    w_carry  = 1'b0;
    w_inv    = 1'b0;
    case (i_opcode)
      OP_SHL: begin
        o_result = w_lsh[WIDTH-1:0];
        w_carry  = w_lsh[WIDTH];
      end
      OP_SHR: begin
        o_result = w_rsh[WIDTH:1];
        w_carry  = w_rsh[0];
      end
      OP_SAR: begin
        o_result = w_ash[WIDTH:1];
        w_carry  = w_ash[0];
      end
      OP_ROL:  o_result = w_rol[2*WIDTH-1:WIDTH];
      OP_ROR:  o_result = w_ror[WIDTH-1:0];
      default: w_inv = 1'b1;
    endcase
  end

  always_comb begin
    o_status           = '0;
    o_status[ST_INV]   = w_inv;
    o_status[ST_ZERO]  = (o_result == '0);
    o_status[ST_SIGN]  = o_result[WIDTH-1];
    o_status[ST_CARRY] = w_carry;
  end

endmodule

// File: rtl/spi_barrel_shifter.sv
// SPI mode-0 slave: receives opcode/A/B, runs the shift ALU, returns {result,status} in the same frame.
module spi_barrel_shifter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  spi_if.SLAVE             spi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status
);
  import spi_shifter_pkg::*;

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned TXW = WIDTH + 4;
  localparam int unsigned CW  = $clog2(TXW) + 1;
  localparam logic [CW-1:0] CNT_OP_LAST = CW'(3);
  localparam logic [CW-1:0] CNT_W_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_TX_LAST = CW'(TXW - 1);

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_nss_sync;
  logic                   r_sclk_q;
  logic                   w_sclk_s, w_mosi_s, w_nss_s;
  logic                   w_rise, w_fall, w_abort, w_miso;

  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [SHW-1:0]   r_amt;
  logic [TXW-1:0]   r_tx;
  logic             r_tx_armed;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_status;
  logic [WIDTH-1:0] w_alu_res;
  logic [3:0]       w_alu_st;

  // nss synchroniser resets to deasserted so no phantom frame starts out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_nss_sync  <= '1;
      r_sclk_q    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], spi.nss};
      r_sclk_q    <= w_sclk_s;
    end
  end

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_nss_s  = r_nss_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk_s & ~r_sclk_q;
  assign w_fall   = ~w_sclk_s & r_sclk_q;
  assign w_abort  = (r_state != IDLE) && w_nss_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (!w_nss_s) w_next = RX_OP;
        RX_OP:    if (w_rise && r_cnt == CNT_OP_LAST) w_next = RX_A;
        RX_A:     if (w_rise && r_cnt == CNT_W_LAST)  w_next = RX_B;
        RX_B:     if (w_rise && r_cnt == CNT_W_LAST)  w_next = EXEC;
        EXEC:     w_next = TX;
        TX:       if (w_rise && r_cnt == CNT_TX_LAST) w_next = WAIT_NSS;
        WAIT_NSS: w_next = WAIT_NSS;
        default:  w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (r_state != IDLE);
    done   = (r_state == EXEC);
    w_miso = (r_state == TX) ? r_tx[TXW-1] : 1'b0;
  end

  assign spi.miso = w_miso;
  assign result   = r_result;
  assign status   = r_status;

  spi_shift_alu #(.WIDTH(WIDTH)) u_alu (
    .i_opcode (r_op),
    .i_a      (r_a),
    .i_amount (r_amt),
    .o_result (w_alu_res),
    .o_status (w_alu_st)
  );

  // Only the low SHW bits of B matter, and they arrive last, so a SHW-bit shifter holds them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_amt      <= '0;
      r_tx       <= '0;
      r_tx_armed <= 1'b0;
      r_result   <= '0;
      r_status   <= '0;
    end else if (w_abort) begin
      r_cnt      <= '0;
      r_tx_armed <= 1'b0;
    end else begin
      case (r_state)
        RX_OP: if (w_rise) begin
          r_op  <= {r_op[2:0], w_mosi_s};
          r_cnt <= (r_cnt == CNT_OP_LAST) ? '0 : r_cnt + 1'b1;
        end
        RX_A: if (w_rise) begin
          r_a   <= {r_a[WIDTH-2:0], w_mosi_s};
          r_cnt <= (r_cnt == CNT_W_LAST) ? '0 : r_cnt + 1'b1;
        end
        RX_B: if (w_rise) begin
          r_amt <= {r_amt[SHW-2:0], w_mosi_s};
          r_cnt <= (r_cnt == CNT_W_LAST) ? '0 : r_cnt + 1'b1;
        end
        EXEC: begin
          r_result   <= w_alu_res;
          r_status   <= w_alu_st;
          r_tx       <= {w_alu_res, w_alu_st};
          r_cnt      <= '0;
          r_tx_armed <= 1'b0;
        end
        TX: begin
          if (w_rise) begin
            r_tx_armed <= 1'b1;
            r_cnt      <= (r_cnt == CNT_TX_LAST) ? '0 : r_cnt + 1'b1;
          end else if (w_fall && r_tx_armed) begin
            r_tx       <= r_tx << 1;
            r_tx_armed <= 1'b0;
          end
        end
        default: begin
          r_cnt      <= '0;
          r_tx_armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_barrel_shifter.sv
// Scoreboard bench: SPI master drives 32- and 8-bit shifters, expectations come from a bit-serial model.
module tb_spi_barrel_shifter;
  import spi_shifter_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 8;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic m_sclk = 1'b0;
  logic m_mosi = 1'b0;
  logic m_nss  = 1'b1;
  logic sel8   = 1'b0;

  always #5 clk = ~clk;

  spi_if bus32 ();
  spi_if bus8 ();

  assign bus32.sclk = sel8 ? 1'b0 : m_sclk;
  assign bus32.nss  = sel8 ? 1'b1 : m_nss;
  assign bus32.mosi = m_mosi;
  assign bus8.sclk  = sel8 ? m_sclk : 1'b0;
  assign bus8.nss   = sel8 ? m_nss : 1'b1;
  assign bus8.mosi  = m_mosi;

  logic        busy32, done32, busy8, done8;
  logic [31:0] res32;
  logic [7:0]  res8;
  logic [3:0]  st32, st8;
  logic        miso_sel;

  assign miso_sel = sel8 ? bus8.miso : bus32.miso;

  spi_barrel_shifter #(.WIDTH(32), .SYNC_STAGES(SYNC)) u_dut32 (
    .clock (clk), .reset (rst_n), .spi (bus32.SLAVE),
    .busy (busy32), .done (done32), .result (res32), .status (st32)
  );

  spi_barrel_shifter #(.WIDTH(8), .SYNC_STAGES(SYNC)) u_dut8 (
    .clock (clk), .reset (rst_n), .spi (bus8.SLAVE),
    .busy (busy8), .done (done8), .result (res8), .status (st8)
  );

  int unsigned n_checks  = 0;
  int unsigned n_pass    = 0;
  int unsigned done_cnt  = 0;
  logic [35:0] sb_q[$];
  logic [35:0] last_exp32;

  always @(posedge clk) begin
    if (sel8 ? done8 : done32) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int unsigned k);
    repeat (k) @(negedge clk);
  endtask

  // Bit-at-a-time reference: shifts/rotates one position per step, tracking the last bit out.
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int unsigned n);
    logic [31:0] mask, r;
    logic        c, inv;
    int unsigned amt;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    amt  = b & (n - 1);
    r    = a & mask;
    c    = 1'b0;
    inv  = !(op inside {OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR});
    if (!inv) begin
      for (int unsigned i = 0; i < amt; i++) begin
        case (op)
          OP_SHL: begin c = r[n-1]; r = (r << 1) & mask; end
          OP_SHR: begin c = r[0];   r = r >> 1; end
          OP_SAR: begin c = r[0];   r = (r >> 1) | (32'(r[n-1]) << (n - 1)); end
          OP_ROL: r = ((r << 1) | (r >> (n - 1))) & mask;
          default: r = (r >> 1) | (32'(r[0]) << (n - 1));
        endcase
      end
    end
    return {r, inv, (r == 32'd0), r[n-1], c};
  endfunction

  task automatic shift_frame(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int unsigned n, input int unsigned stop_bits,
                             output logic [35:0] rx);
    int unsigned total;
    total = 4 + 3 * n + 4;
    rx    = '0;
    m_nss = 1'b0;
    tick(HALF);
    for (int unsigned k = 0; k < total && k < stop_bits; k++) begin
      if (k < 4)              m_mosi = op[3-k];
      else if (k < 4 + n)     m_mosi = a[n-1-(k-4)];
      else if (k < 4 + 2 * n) m_mosi = b[n-1-(k-4-n)];
      else                    m_mosi = 1'b0;
      tick(HALF);
      if (k >= 4 + 2 * n) rx = {rx[34:0], miso_sel};
      m_sclk = 1'b1;
      tick(HALF);
      m_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int unsigned n);
    logic [35:0] rx, exp;
    int unsigned d0;
    sb_q.push_back(model(op, a, b, n));
    d0 = done_cnt;
    shift_frame(op, a, b, n, 1000, rx);
    tick(2);
    check({tag, "_busy_wait"}, sel8 ? busy8 : busy32, 1);
    m_nss = 1'b1;
    tick(SYNC + 3);
    exp = sb_q.pop_front();
    check({tag, "_miso"}, rx, exp);
    check({tag, "_result"}, sel8 ? 32'(res8) : res32, exp[35:4]);
    check({tag, "_status"}, sel8 ? st8 : st32, exp[3:0]);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_busy_idle"}, sel8 ? busy8 : busy32, 0);
    if (!sel8) last_exp32 = exp;
    tick(4);
  endtask

  initial begin
    logic [35:0] rx;
    int unsigned d0;

    tick(3);
    check("rst_busy", busy32, 0);
    check("rst_done", done32, 0);
    check("rst_result", res32, 0);
    check("rst_status", st32, 0);
    check("rst_miso", bus32.miso, 0);
    rst_n = 1'b1;
    tick(5);
    check("post_rst_busy", busy32, 0);

    run_frame("shl",      OP_SHL, 32'h0000_00F1, 32'd4,          32);
    run_frame("shr",      OP_SHR, 32'h0000_0001, 32'd1,          32);
    run_frame("sar31",    OP_SAR, 32'h8000_0000, 32'hFFFF_FFFF,  32);
    run_frame("ror33",    OP_ROR, 32'h0000_0001, 32'd33,         32);
    run_frame("rol",      OP_ROL, 32'h8000_0001, 32'd1,          32);
    run_frame("inv",      4'b0000, 32'h1234_5678, 32'd7,         32);
    run_frame("shl_amt0", OP_SHL, 32'h8000_0000, 32'h0000_0020,  32);
    run_frame("shl31",    OP_SHL, 32'h0000_0003, 32'd31,         32);
    run_frame("sar_pos",  OP_SAR, 32'h4000_0010, 32'd5,          32);

    // Abort partway through A.
    d0 = done_cnt;
    shift_frame(OP_SHL, 32'h0000_FFFF, 32'd3, 32, 4 + 20, rx);
    m_nss = 1'b1;
    tick(SYNC + 2);
    check("abort_busy", busy32, 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_result_kept", res32, last_exp32[35:4]);
    check("abort_status_kept", st32, last_exp32[3:0]);
    tick(6);
    run_frame("after_abort", OP_ROR, 32'h0000_00F0, 32'd4, 32);

    // Reset in the middle of the TX phase.
    shift_frame(OP_ROL, 32'hA5A5_0001, 32'd2, 32, 4 + 64 + 5, rx);
    check("pre_rst_busy", busy32, 1);
    rst_n = 1'b0;
    #1;
    check("midtx_rst_miso", bus32.miso, 0);
    check("midtx_rst_busy", busy32, 0);
    check("midtx_rst_result", res32, 0);
    check("midtx_rst_status", st32, 0);
    tick(2);
    m_nss = 1'b1;
    rst_n = 1'b1;
    tick(6);
    run_frame("after_rst", OP_SHR, 32'hF000_0000, 32'd28, 32);

    sel8 = 1'b1;
    tick(4);
    run_frame("w8_shl",   OP_SHL, 32'h81, 32'h01, 8);
    run_frame("w8_sar",   OP_SAR, 32'h90, 32'h03, 8);
    run_frame("w8_ror9",  OP_ROR, 32'h01, 32'h09, 8);
    run_frame("w8_inv",   4'b1111, 32'h7E, 32'h02, 8);
    sel8 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
